poci_burst_readout_ctrl: RTL and testbench
==========================================

// Module: poci_burst_readout_ctrl
// PURPOSE
//  Sequencer for the POCI readout path. Steps the register-select address of the
//  59:1 readback mux through a burst of consecutive registers and serializes each
//  selected byte LSB-first onto the POCI line. Frames are gapless.
//  Sits between the command decoder (start/start_addr/burst_len) and the readback mux.
// PARAMETERS
//  DATA_W    8   width of one readback register / serial frame payload
//  ADDR_MIN  1   lowest valid register address (address 0 is reserved)
//  ADDR_MAX  59  highest valid register address; the address wraps to ADDR_MIN after it
// PORTS
//  sclk        in   1       serial clock; all state changes on its posedge
//  rstn        in   1       asynchronous active-low reset
//  start       in   1       one-cycle burst request; sampled only in IDLE
//  start_addr  in   8       first register address of the burst
//  burst_len   in   8       number of bytes in the burst, 1..255
//  abort       in   1       synchronous burst cancel
//  mux_data    in   DATA_W  byte from the readback mux for mux_addr (combinational path)
//  mux_addr    out  8       select driven to the readback mux
//  serial_out  out  1       POCI bit stream, registered
//  busy        out  1       high from accepted start until the burst ends
//  byte_done   out  1       one-cycle pulse when the last bit of each frame is driven
//  done        out  1       one-cycle pulse after the final frame of a burst
//  err         out  1       one-cycle pulse when a start request is rejected
// BEHAVIOUR
//  Reset values: mux_addr=0, serial_out=0, busy=0, byte_done=0, done=0, err=0.
//  Internal reset values: state=IDLE, shreg=0, bit index=0, remaining count=0.
//  FSM states: IDLE, LOAD, SHIFT, FIN.
//  IDLE -> LOAD when all of these hold:
//    - start=1
//    - ADDR_MIN <= start_addr <= ADDR_MAX
//    - burst_len != 0
//    On this transition: mux_addr <= start_addr, remaining <= burst_len, busy <= 1.
//  IDLE with start=1 and an invalid start_addr or burst_len=0:
//    - err=1 for one cycle; the FSM stays in IDLE; mux_addr is unchanged.
//  LOAD (exactly 1 cycle):
//    - shreg <= mux_data
//    - mux_addr advances to the next address (prefetch)
//    - bit index <= 0; next state SHIFT
//  SHIFT: each cycle serial_out <= shreg[bit index], then bit index increments.
//  On bit index DATA_W-1, byte_done=1 for one cycle, and:
//    - remaining > 1: shreg <= mux_data, mux_addr advances, remaining decrements,
//      bit index <= 0; the FSM stays in SHIFT with no idle bit between frames.
//    - remaining = 1: next state FIN.
//  FIN (1 cycle):
//    - done=1, busy<=0, serial_out<=0, mux_addr<=0; next state IDLE.
//  Address advance rule: ADDR_MAX -> ADDR_MIN; otherwise +1. mux_addr never equals 0
//  while busy.
//  Latency:
//    - start sampled at edge N; first payload bit visible on serial_out after edge N+2.
//    - busy is high for 2 + burst_len*DATA_W cycles.
//  start while not in IDLE: ignored; no err pulse.
//  abort=1 in any non-IDLE state:
//    - next edge forces IDLE, serial_out=0, busy=0, mux_addr=0
//    - no done, no byte_done; abort takes priority over byte_done/FIN on the same edge.
//  abort in IDLE: no effect, including when start=1 on the same edge (abort wins).
//  rstn low mid-burst: all outputs return to reset values immediately; no done pulse.
//  serial_out is 0 whenever the FSM is not in SHIFT.
// CONFIGURATION
//  POCI_PARITY_EN defined:
//    - each frame is DATA_W+1 bits: payload LSB-first, then an odd-parity bit
//      (^payload inverted).
//    - byte_done and the next-byte load occur on the parity bit.
//    - busy is high for 2 + burst_len*(DATA_W+1) cycles.
//  POCI_PARITY_EN undefined: DATA_W-bit frames; no parity logic is synthesized.
// TESTING
//  1. start_addr=5, burst_len=1, reg5=0xA5
//     -> serial_out 1,0,1,0,0,1,0,1 from edge N+2; done one cycle after bit 7; busy 10 cycles.
//  2. start_addr=58, burst_len=3, regs 58/59/1 = 0x01/0x80/0xFF
//     -> 24 contiguous bits; mux_addr sequence 58,59,1; three byte_done pulses.
//  3. start_addr=0 or 60, or burst_len=0
//     -> err one-cycle pulse; busy stays 0; serial_out stays 0.
//  4. start_addr=10, burst_len=4, abort raised at bit 3 of byte 2
//     -> IDLE next edge; no done; busy=0.
//     A new start on the following cycle is accepted.
//  5. Second start during an active burst -> ignored; no err pulse; first burst completes intact.
//  6. rstn low during SHIFT -> all outputs 0 asynchronously.
//     With POCI_PARITY_EN and reg=0x03: a 9-bit frame ending in parity bit 1.

Source files
------------

// File: rtl/poci_burst_readout_ctrl.sv
// rtl/poci_burst_readout_ctrl.sv - POCI burst readout sequencer and serializer
//
// Purpose:
//   Walks the readback-mux register select through a burst of consecutive
//   addresses (wrapping ADDR_MAX -> ADDR_MIN) and shifts each selected byte
//   out LSB-first on the POCI line, with no gap between frames.
//
// Ports:
//   sclk        in   serial clock, all state changes on posedge
//   rstn        in   asynchronous active-low reset
//   start       in   one-cycle burst request, sampled only in IDLE
//   start_addr  in   first register address of the burst
//   burst_len   in   number of bytes in the burst (1..255)
//   abort       in   synchronous burst cancel
//   mux_data    in   readback mux byte for mux_addr (combinational)
//   mux_addr    out  register select to the readback mux
//   serial_out  out  registered POCI bit stream
//   busy        out  high from accepted start until the burst ends
//   byte_done   out  pulse when the last bit of a frame is driven
//   done        out  pulse after the final frame of a burst
//   err         out  pulse when a start request is rejected
//
// Configuration:
//   POCI_PARITY_EN - append an odd-parity bit to every frame.

module poci_burst_readout_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_MIN = 1,
  parameter int ADDR_MAX = 59
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        start_addr,
  input  logic [7:0]        burst_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] mux_data,
  output logic [7:0]        mux_addr,
  output logic              serial_out,
  output logic              busy,
  output logic              byte_done,
  output logic              done,
  output logic              err
);

`ifdef POCI_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int IDX_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);
  localparam logic [7:0] A_MIN = 8'(ADDR_MIN);
  localparam logic [7:0] A_MAX = 8'(ADDR_MAX);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [7:0]        remaining_q;
  logic [7:0]        mux_addr_q;
  logic              serial_q;
  logic              busy_q;
  logic              byte_done_q;
  logic              done_q;
  logic              err_q;
`ifdef POCI_PARITY_EN
  logic              par_q;
`endif

  logic [7:0] addr_adv_d;
  logic       start_ok_d;

  always_comb begin
    addr_adv_d = (mux_addr_q >= A_MAX) ? A_MIN : mux_addr_q + 8'd1;
    start_ok_d = (start_addr >= A_MIN) && (start_addr <= A_MAX) && (burst_len != 8'd0);
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      remaining_q <= '0;
      mux_addr_q  <= '0;
      serial_q    <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef POCI_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      byte_done_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      // Abort outranks everything, including the frame end and FIN pulses.
      if (abort && (state_q != IDLE)) begin
        state_q     <= IDLE;
        serial_q    <= 1'b0;
        busy_q      <= 1'b0;
        mux_addr_q  <= '0;
        remaining_q <= '0;
        bit_idx_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            // abort in IDLE suppresses both acceptance and the err pulse
            if (start && !abort) begin
              if (start_ok_d) begin
                state_q     <= LOAD;
                mux_addr_q  <= start_addr;
                remaining_q <= burst_len;
                busy_q      <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          LOAD: begin
            shreg_q    <= mux_data;
`ifdef POCI_PARITY_EN
            par_q      <= ~^mux_data;
`endif
            // Prefetch: the mux settles on the next byte while this one shifts.
            mux_addr_q <= addr_adv_d;
            bit_idx_q  <= '0;
            state_q    <= SHIFT;
          end
          SHIFT: begin
            // Right shift keeps the current payload bit at shreg_q[0].
`ifdef POCI_PARITY_EN
            serial_q <= (bit_idx_q == LAST_IDX) ? par_q : shreg_q[0];
`else
            serial_q <= shreg_q[0];
`endif
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + IDX_W'(1);
            if (bit_idx_q == LAST_IDX) begin
              byte_done_q <= 1'b1;
              bit_idx_q   <= '0;
              if (remaining_q > 8'd1) begin
                shreg_q     <= mux_data;
`ifdef POCI_PARITY_EN
                par_q       <= ~^mux_data;
`endif
                mux_addr_q  <= addr_adv_d;
                remaining_q <= remaining_q - 8'd1;
              end else begin
                state_q <= FIN;
              end
            end
          end
          FIN: begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            serial_q    <= 1'b0;
            mux_addr_q  <= '0;
            remaining_q <= '0;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mux_addr   = mux_addr_q;
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign byte_done  = byte_done_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_poci_burst_readout_ctrl.sv
// tb/tb_poci_burst_readout_ctrl.sv - self-checking bench for poci_burst_readout_ctrl
module tb_poci_burst_readout_ctrl;

`ifdef POCI_PARITY_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif

  logic       sclk;
  logic       rstn;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] burst_len;
  logic       abort;
  logic [7:0] mux_data;
  logic [7:0] mux_addr;
  logic       serial_out;
  logic       busy;
  logic       byte_done;
  logic       done;
  logic       err;

  logic [7:0] regs [0:255];
  bit         exp_bits [$];
  logic [7:0] exp_addr0;
  int         bd_cnt;
  int         bcnt;
  int         n_cmp;
  int         n_err;

  poci_burst_readout_ctrl dut (
    .sclk       (sclk),
    .rstn       (rstn),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .abort      (abort),
    .mux_data   (mux_data),
    .mux_addr   (mux_addr),
    .serial_out (serial_out),
    .busy       (busy),
    .byte_done  (byte_done),
    .done       (done),
    .err        (err)
  );

  assign mux_data = regs[mux_addr];

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] adv(input logic [7:0] a);
    return (a == 8'd59) ? 8'd1 : a + 8'd1;
  endfunction

  // Scoreboard push: expected serial bits for a whole burst.
  task automatic push_burst(input logic [7:0] a, input logic [7:0] l);
    logic [7:0] addr;
    logic [7:0] b;
    addr      = a;
    exp_addr0 = a;
    bd_cnt    = 0;
    for (int k = 0; k < int'(l); k++) begin
      b = regs[addr];
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      if (FW == 9) exp_bits.push_back(~^b);
      addr = adv(addr);
    end
  endtask

  // Monitor: pops one expected bit per payload cycle while busy.
  always @(negedge sclk) begin
    if (!rstn || !busy) begin
      bcnt = 0;
    end else begin
      if (bcnt == 0) chk("first_addr", mux_addr, exp_addr0);
      chk("addr_nonzero", mux_addr != 8'd0, 1);
      chk("err_while_busy", err, 0);
      chk("done_while_busy", done, 0);
      if (bcnt >= 2) begin
        if (exp_bits.size() == 0) chk("extra_bit", 1, 0);
        else chk("serial_bit", serial_out, exp_bits.pop_front());
        chk("byte_done_pos", byte_done, ((bcnt - 2) % FW) == FW - 1);
      end else begin
        chk("serial_pre", serial_out, 0);
        chk("byte_done_pre", byte_done, 0);
      end
      if (byte_done) bd_cnt++;
      bcnt++;
    end
  end

  task automatic run_burst(input logic [7:0] a, input logic [7:0] l, input int inj);
    int cyc;
    push_burst(a, l);
    start = 1'b1; start_addr = a; burst_len = l;
    @(negedge sclk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 3000) begin
      cyc++;
      @(negedge sclk);
      if (inj != 0 && cyc == inj) begin
        start = 1'b1; start_addr = 8'd40; burst_len = 8'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("busy_cycles", cyc, 2 + int'(l) * FW);
    chk("done_pulse", done, 1);
    chk("err_none", err, 0);
    chk("serial_after", serial_out, 0);
    chk("addr_after", mux_addr, 0);
    chk("bits_left", exp_bits.size(), 0);
    chk("byte_done_count", bd_cnt, int'(l));
    @(negedge sclk);
    chk("done_one_cycle", done, 0);
    exp_bits.delete();
  endtask

  task automatic reject(input logic [7:0] a, input logic [7:0] l);
    start = 1'b1; start_addr = a; burst_len = l;
    @(negedge sclk);
    start = 1'b0;
    chk("rej_err", err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_serial", serial_out, 0);
    chk("rej_addr", mux_addr, 0);
    @(negedge sclk);
    chk("rej_err_pulse", err, 0);
    chk("rej_busy2", busy, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; bd_cnt = 0; bcnt = 0; exp_addr0 = 8'd0;
    rstn = 1'b0; start = 1'b0; start_addr = 8'd0; burst_len = 8'd0; abort = 1'b0;
    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
    regs[5] = 8'hA5; regs[58] = 8'h01; regs[59] = 8'h80; regs[1] = 8'hFF; regs[7] = 8'h03;
    repeat (3) @(negedge sclk);
    chk("rst_mux_addr", mux_addr, 0);
    chk("rst_serial", serial_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_byte_done", byte_done, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;
    @(negedge sclk);

    // Single byte 0xA5 from register 5.
    run_burst(8'd5, 8'd1, 0);
    // Wrap burst 58, 59, 1.
    run_burst(8'd58, 8'd3, 0);

    // Rejected requests.
    reject(8'd0, 8'd1);
    reject(8'd60, 8'd1);
    reject(8'd5, 8'd0);
    reject(8'd255, 8'd2);

    // Abort in IDLE beats a valid start on the same edge.
    start = 1'b1; start_addr = 8'd5; burst_len = 8'd1; abort = 1'b1;
    @(negedge sclk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_err", err, 0);
    chk("idle_abort_addr", mux_addr, 0);

    // Abort at bit 3 of the second byte of a 4-byte burst from 10.
    push_burst(8'd10, 8'd4);
    start = 1'b1; start_addr = 8'd10; burst_len = 8'd4;
    @(negedge sclk);
    start = 1'b0;
    repeat (2 + FW + 3) @(negedge sclk);
    abort = 1'b1;
    @(negedge sclk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_byte_done", byte_done, 0);
    chk("abort_serial", serial_out, 0);
    chk("abort_addr", mux_addr, 0);
    chk("abort_bits_consumed", exp_bits.size(), 4 * FW - (FW + 4));
    exp_bits.delete();
    // Restart on the very next cycle.
    run_burst(8'd20, 8'd2, 0);

    // Second start mid-burst is ignored.
    run_burst(8'd30, 8'd2, 5);

    // Async reset mid-SHIFT.
    push_burst(8'd7, 8'd2);
    start = 1'b1; start_addr = 8'd7; burst_len = 8'd2;
    @(negedge sclk);
    start = 1'b0;
    repeat (6) @(negedge sclk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_serial", serial_out, 0);
    chk("arst_addr", mux_addr, 0);
    chk("arst_done", done, 0);
    chk("arst_byte_done", byte_done, 0);
    exp_bits.delete();
    @(negedge sclk);
    @(negedge sclk);
    chk("arst_hold_done", done, 0);
    rstn = 1'b1;
    @(negedge sclk);

    // 0x03 frame: parity bit 1 when parity is enabled.
    run_burst(8'd7, 8'd1, 0);
    // Random-address multi-byte burst.
    run_burst(8'(1 + $urandom_range(0, 58)), 8'd5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
